// File: rtl/sram_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sram_port_arbiter
//  Purpose  : Front end for a dual-port (1RW + 1R) SRAM macro.
//             - After reset it optionally zero-fills the whole array through
//               port 0, then raises ready_o.
//             - Port 0 (read/write) is shared between a data master (d_*)
//               and a debug master (dbg_*) with one-bit round-robin priority.
//             - Port 1 (read-only) serves instruction fetch (if_*). A fetch
//               is held off for one cycle when port 0 writes the same word.
//             - Grants are combinational; read data returns one cycle after
//               the grant, straight from the SRAM dout of the matching port.
//  Ports    : clk_i, reset_i (sync, active-high), ready_o
//             if_req_i/if_addr_i -> if_gnt_o, if_rvalid_o/if_rdata_o
//             d_* / dbg_*  : req, we, wmask, addr, wdata -> gnt, rvalid, rdata
//             sram_*0      : port-0 csb/web (active-low), wmask, addr, din, dout
//             sram_*1      : port-1 csb, addr, dout; web/wmask/din tied off
//  Revision : 1.0  initial release
// ============================================================================
module sram_port_arbiter #(
    parameter int ADDR_WIDTH     = 9,
    parameter int DATA_WIDTH     = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    output logic                    ready_o,

    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    output logic                    if_gnt_o,
    output logic                    if_rvalid_o,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,

    input  logic                    d_req_i,
    input  logic                    d_we_i,
    input  logic [DATA_WIDTH/8-1:0] d_wmask_i,
    input  logic [ADDR_WIDTH-1:0]   d_addr_i,
    input  logic [DATA_WIDTH-1:0]   d_wdata_i,
    output logic                    d_gnt_o,
    output logic                    d_rvalid_o,
    output logic [DATA_WIDTH-1:0]   d_rdata_o,

    input  logic                    dbg_req_i,
    input  logic                    dbg_we_i,
    input  logic [DATA_WIDTH/8-1:0] dbg_wmask_i,
    input  logic [ADDR_WIDTH-1:0]   dbg_addr_i,
    input  logic [DATA_WIDTH-1:0]   dbg_wdata_i,
    output logic                    dbg_gnt_o,
    output logic                    dbg_rvalid_o,
    output logic [DATA_WIDTH-1:0]   dbg_rdata_o,

    output logic                    sram_csb0_o,
    output logic                    sram_web0_o,
    output logic [DATA_WIDTH/8-1:0] sram_wmask0_o,
    output logic [ADDR_WIDTH-1:0]   sram_addr0_o,
    output logic [DATA_WIDTH-1:0]   sram_din0_o,
    input  logic [DATA_WIDTH-1:0]   sram_dout0_i,

    output logic                    sram_csb1_o,
    output logic                    sram_web1_o,
    output logic [DATA_WIDTH/8-1:0] sram_wmask1_o,
    output logic [ADDR_WIDTH-1:0]   sram_addr1_o,
    output logic [DATA_WIDTH-1:0]   sram_din1_o,
    input  logic [DATA_WIDTH-1:0]   sram_dout1_i
);

    localparam int c_MASK_W = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] c_CNT_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] c_CNT_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t c_RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [ADDR_WIDTH-1:0] w_clr_cnt_nxt;
    logic                  w_clearing;

    logic                  r_prio_dbg;     // 1: dbg wins a tie, 0: d wins
    logic                  r_d_rd;         // read owner of the port-0 data due now
    logic                  r_dbg_rd;
    logic                  r_if_rd;

    logic                  w_ready;
    logic                  w_clr_drive;
    logic                  w_d_gnt;
    logic                  w_dbg_gnt;
    logic                  w_p0_gnt;
    logic                  w_sel_we;
    logic [c_MASK_W-1:0]   w_sel_wmask;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_hazard;
    logic                  w_if_gnt;

    // ------------------------------------------------------------------
    // Clear / ready state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= c_RESET_STATE;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_clearing    = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clearing    = 1'b1;
                w_clr_cnt_nxt = r_clr_cnt + c_CNT_ONE;
                if (r_clr_cnt == c_CNT_LAST) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                w_state_nxt = ST_READY;
            end
            default: begin
                w_state_nxt = c_RESET_STATE;
            end
        endcase
    end

    // Reset is folded in combinationally so that every cycle in which reset
    // is sampled high shows idle SRAM ports, no grants and no rvalid.
    assign w_ready     = (r_state == ST_READY) && !reset_i;
    assign w_clr_drive = w_clearing && !reset_i;
    assign ready_o     = w_ready;

    // ------------------------------------------------------------------
    // Port-0 round-robin arbitration (d vs dbg)
    // ------------------------------------------------------------------
    assign w_d_gnt   = w_ready && d_req_i   && (!dbg_req_i || !r_prio_dbg);
    assign w_dbg_gnt = w_ready && dbg_req_i && (!d_req_i   ||  r_prio_dbg);
    assign w_p0_gnt  = w_d_gnt || w_dbg_gnt;

    assign d_gnt_o   = w_d_gnt;
    assign dbg_gnt_o = w_dbg_gnt;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_prio_dbg <= 1'b0;
        end else if (w_d_gnt) begin
            r_prio_dbg <= 1'b1;
        end else if (w_dbg_gnt) begin
            r_prio_dbg <= 1'b0;
        end
    end

    assign w_sel_we    = w_dbg_gnt ? dbg_we_i    : d_we_i;
    assign w_sel_wmask = w_dbg_gnt ? dbg_wmask_i : d_wmask_i;
    assign w_sel_addr  = w_dbg_gnt ? dbg_addr_i  : d_addr_i;
    assign w_sel_wdata = w_dbg_gnt ? dbg_wdata_i : d_wdata_i;

    always_comb begin
        sram_csb0_o   = 1'b1;
        sram_web0_o   = 1'b0;
        sram_wmask0_o = '0;
        sram_addr0_o  = '0;
        sram_din0_o   = '0;
        if (w_clr_drive) begin
            sram_csb0_o   = 1'b0;
            sram_web0_o   = 1'b0;
            sram_wmask0_o = '1;
            sram_addr0_o  = r_clr_cnt;
        end else if (w_p0_gnt) begin
            sram_csb0_o   = 1'b0;
            sram_web0_o   = !w_sel_we;
            sram_wmask0_o = w_sel_we ? w_sel_wmask : '0;
            sram_addr0_o  = w_sel_addr;
            sram_din0_o   = w_sel_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Port 1: fetch, stalled when port 0 writes the same word this cycle
    // (the macro gives no defined read-during-write result across ports).
    // ------------------------------------------------------------------
    assign w_hazard = w_p0_gnt && w_sel_we && (w_sel_addr == if_addr_i);
    assign w_if_gnt = if_req_i && w_ready && !w_hazard;

    assign if_gnt_o      = w_if_gnt;
    assign sram_csb1_o   = !w_if_gnt;
    assign sram_addr1_o  = w_if_gnt ? if_addr_i : '0;
    assign sram_web1_o   = 1'b1;
    assign sram_wmask1_o = '0;
    assign sram_din1_o   = '0;

    // ------------------------------------------------------------------
    // Read-return tracking: one-cycle SRAM latency, data taken directly
    // from the macro outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_d_rd   <= 1'b0;
            r_dbg_rd <= 1'b0;
            r_if_rd  <= 1'b0;
        end else begin
            r_d_rd   <= w_d_gnt   && !d_we_i;
            r_dbg_rd <= w_dbg_gnt && !dbg_we_i;
            r_if_rd  <= w_if_gnt;
        end
    end

    assign d_rvalid_o   = r_d_rd   && !reset_i;
    assign dbg_rvalid_o = r_dbg_rd && !reset_i;
    assign if_rvalid_o  = r_if_rd  && !reset_i;

    assign d_rdata_o    = sram_dout0_i;
    assign dbg_rdata_o  = sram_dout0_i;
    assign if_rdata_o   = sram_dout1_i;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sram_port_arbiter
//  Purpose  : Directed self-checking bench for sram_port_arbiter with a
//             behavioural 512x32 1RW+1R SRAM (one-cycle read latency).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_port_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        ready_o;
    logic        if_req_i;
    logic [8:0]  if_addr_i;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i, d_we_i;
    logic [3:0]  d_wmask_i;
    logic [8:0]  d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_gnt_o, d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        dbg_req_i, dbg_we_i;
    logic [3:0]  dbg_wmask_i;
    logic [8:0]  dbg_addr_i;
    logic [31:0] dbg_wdata_i;
    logic        dbg_gnt_o, dbg_rvalid_o;
    logic [31:0] dbg_rdata_o;
    logic        sram_csb0_o, sram_web0_o;
    logic [3:0]  sram_wmask0_o;
    logic [8:0]  sram_addr0_o;
    logic [31:0] sram_din0_o, sram_dout0_i;
    logic        sram_csb1_o, sram_web1_o;
    logic [3:0]  sram_wmask1_o;
    logic [8:0]  sram_addr1_o;
    logic [31:0] sram_din1_o, sram_dout1_i;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    sram_port_arbiter #(
        .ADDR_WIDTH     (9),
        .DATA_WIDTH     (32),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .ready_o       (ready_o),
        .if_req_i      (if_req_i),
        .if_addr_i     (if_addr_i),
        .if_gnt_o      (if_gnt_o),
        .if_rvalid_o   (if_rvalid_o),
        .if_rdata_o    (if_rdata_o),
        .d_req_i       (d_req_i),
        .d_we_i        (d_we_i),
        .d_wmask_i     (d_wmask_i),
        .d_addr_i      (d_addr_i),
        .d_wdata_i     (d_wdata_i),
        .d_gnt_o       (d_gnt_o),
        .d_rvalid_o    (d_rvalid_o),
        .d_rdata_o     (d_rdata_o),
        .dbg_req_i     (dbg_req_i),
        .dbg_we_i      (dbg_we_i),
        .dbg_wmask_i   (dbg_wmask_i),
        .dbg_addr_i    (dbg_addr_i),
        .dbg_wdata_i   (dbg_wdata_i),
        .dbg_gnt_o     (dbg_gnt_o),
        .dbg_rvalid_o  (dbg_rvalid_o),
        .dbg_rdata_o   (dbg_rdata_o),
        .sram_csb0_o   (sram_csb0_o),
        .sram_web0_o   (sram_web0_o),
        .sram_wmask0_o (sram_wmask0_o),
        .sram_addr0_o  (sram_addr0_o),
        .sram_din0_o   (sram_din0_o),
        .sram_dout0_i  (sram_dout0_i),
        .sram_csb1_o   (sram_csb1_o),
        .sram_web1_o   (sram_web1_o),
        .sram_wmask1_o (sram_wmask1_o),
        .sram_addr1_o  (sram_addr1_o),
        .sram_din1_o   (sram_din1_o),
        .sram_dout1_i  (sram_dout1_i)
    );

    // ---------------- behavioural SRAM (1RW port 0, 1R port 1) ----------------
    logic [31:0] mem [0:511];
    logic [31:0] mdl_old;
    logic [31:0] mdl_merged;

    assign mdl_old    = mem[sram_addr0_o];
    assign mdl_merged = {sram_wmask0_o[3] ? sram_din0_o[31:24] : mdl_old[31:24],
                         sram_wmask0_o[2] ? sram_din0_o[23:16] : mdl_old[23:16],
                         sram_wmask0_o[1] ? sram_din0_o[15:8]  : mdl_old[15:8],
                         sram_wmask0_o[0] ? sram_din0_o[7:0]   : mdl_old[7:0]};

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h5A5A_0000 + i;
        sram_dout0_i = 32'hX;
        sram_dout1_i = 32'hX;
    end

    always @(posedge clk_i) begin
        if (!sram_csb0_o) begin
            if (!sram_web0_o) mem[sram_addr0_o] <= mdl_merged;
            else              sram_dout0_i <= mem[sram_addr0_o];
        end
        if (!sram_csb1_o) sram_dout1_i <= mem[sram_addr1_o];
    end

    // ---------------- helpers for stimulus timing ----------------
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_i = 0; if_addr_i = '0;
        d_req_i = 0; d_we_i = 0; d_wmask_i = '0; d_addr_i = '0; d_wdata_i = '0;
        dbg_req_i = 0; dbg_we_i = 0; dbg_wmask_i = '0; dbg_addr_i = '0; dbg_wdata_i = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        reset_i  = 1;
        d_req_i  = 1; dbg_req_i = 1; if_req_i = 1;
        dbg_addr_i = 9'h1FF;
        next_cycle();
        next_cycle();
        @(negedge clk_i);
        n_checks++;
        if ({ready_o, d_gnt_o, dbg_gnt_o, if_gnt_o} !== 4'b0000)
            $display("FAIL reset_gnt_ready: got %b want 0000", {ready_o, d_gnt_o, dbg_gnt_o, if_gnt_o});
        else n_pass++;
        n_checks++;
        if ({sram_csb0_o, sram_csb1_o, d_rvalid_o, dbg_rvalid_o, if_rvalid_o} !== 5'b11000)
            $display("FAIL reset_csb_rvalid: got %b want 11000",
                     {sram_csb0_o, sram_csb1_o, d_rvalid_o, dbg_rvalid_o, if_rvalid_o});
        else n_pass++;
        n_checks++;
        if ({sram_web1_o, sram_wmask1_o, sram_din1_o} !== {1'b1, 4'h0, 32'h0})
            $display("FAIL port1_tieoff: got %b/%h/%h want 1/0/0", sram_web1_o, sram_wmask1_o, sram_din1_o);
        else n_pass++;
        next_cycle();
        reset_i = 0;
    endtask

    // Runs the clear sequence from address 0, requests still held high.
    task automatic run_clear(input string tag);
        logic [8:0]  ea;
        logic [52:0] got;
        logic [52:0] exp;
        for (int i = 0; i < 512; i++) begin
            ea = i[8:0];
            @(negedge clk_i);
            got = {sram_csb0_o, sram_web0_o, sram_wmask0_o, sram_addr0_o, sram_din0_o,
                   ready_o, d_gnt_o, dbg_gnt_o, if_gnt_o, sram_csb1_o, d_rvalid_o};
            exp = {1'b0, 1'b0, 4'hF, ea, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            n_checks++;
            if (got !== exp)
                $display("FAIL %s_cycle_%0d: got %h want %h", tag, i, got, exp);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_clear();
        d_req_i = 1; dbg_req_i = 1; if_req_i = 1;
        d_addr_i = 9'h000; dbg_addr_i = 9'h1FF; if_addr_i = 9'h000;
        run_clear("clear");
        // cycle 513: ready, first grants (priority starts at d)
        @(negedge clk_i);
        n_checks++;
        if ({ready_o, d_gnt_o, dbg_gnt_o, if_gnt_o} !== 4'b1101)
            $display("FAIL ready_first_gnt: got %b want 1101", {ready_o, d_gnt_o, dbg_gnt_o, if_gnt_o});
        else n_pass++;
        n_checks++;
        if ({sram_csb0_o, sram_web0_o, sram_wmask0_o, sram_addr0_o, sram_csb1_o, sram_addr1_o}
                !== {1'b0, 1'b1, 4'h0, 9'h000, 1'b0, 9'h000})
            $display("FAIL first_read_ports: got %b/%b/%h/%h/%b/%h want 0/1/0/000/0/000",
                     sram_csb0_o, sram_web0_o, sram_wmask0_o, sram_addr0_o, sram_csb1_o, sram_addr1_o);
        else n_pass++;
        next_cycle();
        d_req_i = 0; if_req_i = 0;
        @(negedge clk_i);
        n_checks++;
        if ({d_rvalid_o, d_rdata_o, if_rvalid_o, if_rdata_o, dbg_gnt_o, sram_addr0_o}
                !== {1'b1, 32'h0, 1'b1, 32'h0, 1'b1, 9'h1FF})
            $display("FAIL cleared_addr0_read: got d %b/%h if %b/%h dbg_gnt %b a0 %h want 1/0 1/0 1 1ff",
                     d_rvalid_o, d_rdata_o, if_rvalid_o, if_rdata_o, dbg_gnt_o, sram_addr0_o);
        else n_pass++;
        next_cycle();
        dbg_req_i = 0;
        @(negedge clk_i);
        n_checks++;
        if ({dbg_rvalid_o, dbg_rdata_o, d_rvalid_o} !== {1'b1, 32'h0, 1'b0})
            $display("FAIL cleared_addr511_read: got %b/%h d_rv %b want 1/0 0",
                     dbg_rvalid_o, dbg_rdata_o, d_rvalid_o);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_round_robin();
        // A: d writes 5, dbg reads 5; priority is d
        d_req_i = 1; d_we_i = 1; d_addr_i = 9'd5; d_wdata_i = 32'hDEADBEEF; d_wmask_i = 4'hF;
        dbg_req_i = 1; dbg_we_i = 0; dbg_addr_i = 9'd5; dbg_wdata_i = 32'h12345678;
        @(negedge clk_i);
        n_checks++;
        if ({d_gnt_o, dbg_gnt_o, sram_csb0_o, sram_web0_o, sram_wmask0_o, sram_addr0_o, sram_din0_o}
                !== {1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 9'd5, 32'hDEADBEEF})
            $display("FAIL rr_a_d_write: got gnt %b%b p0 %b%b/%h/%h/%h want 10 00/f/005/deadbeef",
                     d_gnt_o, dbg_gnt_o, sram_csb0_o, sram_web0_o, sram_wmask0_o, sram_addr0_o, sram_din0_o);
        else n_pass++;
        next_cycle();
        // B: d now reads 5; dbg must win
        d_we_i = 0;
        @(negedge clk_i);
        n_checks++;
        if ({d_gnt_o, dbg_gnt_o, d_rvalid_o, sram_csb0_o, sram_web0_o, sram_wmask0_o, sram_addr0_o, sram_din0_o}
                !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 9'd5, 32'h12345678})
            $display("FAIL rr_b_dbg_read: got gnt %b%b rv %b p0 %b%b/%h/%h/%h want 01 0 01/0/005/12345678",
                     d_gnt_o, dbg_gnt_o, d_rvalid_o, sram_csb0_o, sram_web0_o, sram_wmask0_o,
                     sram_addr0_o, sram_din0_o);
        else n_pass++;
        next_cycle();
        // C: dbg reads 6; d wins
        dbg_addr_i = 9'd6;
        @(negedge clk_i);
        n_checks++;
        if ({dbg_rvalid_o, dbg_rdata_o, d_rvalid_o, d_gnt_o, dbg_gnt_o}
                !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0})
            $display("FAIL rr_c: got dbg_rv %b %h d_rv %b gnt %b%b want 1 deadbeef 0 10",
                     dbg_rvalid_o, dbg_rdata_o, d_rvalid_o, d_gnt_o, dbg_gnt_o);
        else n_pass++;
        next_cycle();
        // D: d done; dbg wins again
        d_req_i = 0;
        @(negedge clk_i);
        n_checks++;
        if ({d_rvalid_o, d_rdata_o, dbg_rvalid_o, dbg_gnt_o, sram_addr0_o}
                !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 9'd6})
            $display("FAIL rr_d: got d_rv %b %h dbg_rv %b dbg_gnt %b a0 %h want 1 deadbeef 0 1 006",
                     d_rvalid_o, d_rdata_o, dbg_rvalid_o, dbg_gnt_o, sram_addr0_o);
        else n_pass++;
        next_cycle();
        // E: idle
        dbg_req_i = 0;
        @(negedge clk_i);
        n_checks++;
        if ({dbg_rvalid_o, dbg_rdata_o, d_gnt_o, dbg_gnt_o, sram_csb0_o, sram_web0_o,
             sram_wmask0_o, sram_addr0_o, sram_din0_o}
                !== {1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 9'h0, 32'h0})
            $display("FAIL rr_e_idle: got dbg_rv %b %h gnt %b%b p0 %b%b/%h/%h/%h want 1 0 00 10/0/000/0",
                     dbg_rvalid_o, dbg_rdata_o, d_gnt_o, dbg_gnt_o, sram_csb0_o, sram_web0_o,
                     sram_wmask0_o, sram_addr0_o, sram_din0_o);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_byte_mask();
        d_req_i = 1; d_we_i = 1; d_addr_i = 9'h10; d_wdata_i = 32'h11223344; d_wmask_i = 4'b0101;
        @(negedge clk_i);
        n_checks++;
        if ({d_gnt_o, sram_web0_o, sram_wmask0_o} !== {1'b1, 1'b0, 4'b0101})
            $display("FAIL mask_write: got gnt %b web %b mask %b want 1 0 0101", d_gnt_o, sram_web0_o, sram_wmask0_o);
        else n_pass++;
        next_cycle();
        // zero-mask write: granted, changes nothing
        d_wdata_i = 32'hFFFFFFFF; d_wmask_i = 4'b0000;
        @(negedge clk_i);
        n_checks++;
        if ({d_gnt_o, d_rvalid_o, sram_csb0_o, sram_web0_o, sram_wmask0_o} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0})
            $display("FAIL zero_mask_write: got gnt %b rv %b csb %b web %b mask %b want 1 0 0 0 0000",
                     d_gnt_o, d_rvalid_o, sram_csb0_o, sram_web0_o, sram_wmask0_o);
        else n_pass++;
        next_cycle();
        d_we_i = 0;
        @(negedge clk_i);
        n_checks++;
        if ({d_gnt_o, d_rvalid_o} !== 2'b10)
            $display("FAIL mask_readback_gnt: got gnt %b rv %b want 1 0", d_gnt_o, d_rvalid_o);
        else n_pass++;
        next_cycle();
        d_req_i = 0;
        @(negedge clk_i);
        n_checks++;
        if ({d_rvalid_o, d_rdata_o} !== {1'b1, 32'h00220044})
            $display("FAIL mask_readback: got %b/%h want 1/00220044", d_rvalid_o, d_rdata_o);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_hazard();
        d_req_i = 1; d_we_i = 1; d_addr_i = 9'h20; d_wdata_i = 32'hCAFEF00D; d_wmask_i = 4'hF;
        if_req_i = 1; if_addr_i = 9'h20;
        @(negedge clk_i);
        n_checks++;
        if ({d_gnt_o, if_gnt_o, sram_csb1_o, sram_addr1_o} !== {1'b1, 1'b0, 1'b1, 9'h0})
            $display("FAIL hazard_stall: got d_gnt %b if_gnt %b csb1 %b a1 %h want 1 0 1 000",
                     d_gnt_o, if_gnt_o, sram_csb1_o, sram_addr1_o);
        else n_pass++;
        next_cycle();
        // write to a different word does not stall the retried fetch
        d_addr_i = 9'h21; d_wdata_i = 32'h0BADF00D;
        @(negedge clk_i);
        n_checks++;
        if ({d_gnt_o, if_gnt_o, sram_csb1_o, sram_addr1_o} !== {1'b1, 1'b1, 1'b0, 9'h20})
            $display("FAIL hazard_retry: got d_gnt %b if_gnt %b csb1 %b a1 %h want 1 1 0 020",
                     d_gnt_o, if_gnt_o, sram_csb1_o, sram_addr1_o);
        else n_pass++;
        next_cycle();
        d_req_i = 0; if_addr_i = 9'h21;
        @(negedge clk_i);
        n_checks++;
        if ({if_rvalid_o, if_rdata_o, if_gnt_o} !== {1'b1, 32'hCAFEF00D, 1'b1})
            $display("FAIL fetch_new_data: got %b/%h gnt %b want 1/cafef00d 1", if_rvalid_o, if_rdata_o, if_gnt_o);
        else n_pass++;
        next_cycle();
        if_addr_i = 9'h10;
        @(negedge clk_i);
        n_checks++;
        if ({if_rvalid_o, if_rdata_o, if_gnt_o} !== {1'b1, 32'h0BADF00D, 1'b1})
            $display("FAIL fetch_b2b_1: got %b/%h gnt %b want 1/0badf00d 1", if_rvalid_o, if_rdata_o, if_gnt_o);
        else n_pass++;
        next_cycle();
        if_req_i = 0;
        @(negedge clk_i);
        n_checks++;
        if ({if_rvalid_o, if_rdata_o, sram_csb1_o} !== {1'b1, 32'h00220044, 1'b1})
            $display("FAIL fetch_b2b_2: got %b/%h csb1 %b want 1/00220044 1", if_rvalid_o, if_rdata_o, sram_csb1_o);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_reset_mid_clear();
        // read granted, then reset: its rvalid must not appear
        d_req_i = 1; d_we_i = 0; d_addr_i = 9'd5;
        @(negedge clk_i);
        n_checks++;
        if (d_gnt_o !== 1'b1) $display("FAIL pre_reset_read_gnt: got %b want 1", d_gnt_o);
        else n_pass++;
        next_cycle();
        reset_i = 1; d_req_i = 0;
        @(negedge clk_i);
        n_checks++;
        if ({d_rvalid_o, ready_o, sram_csb0_o} !== 3'b001)
            $display("FAIL reset_kills_rvalid: got rv %b ready %b csb0 %b want 0 0 1", d_rvalid_o, ready_o, sram_csb0_o);
        else n_pass++;
        next_cycle();
        reset_i = 0;
        d_req_i = 1; dbg_req_i = 1; if_req_i = 1;
        d_addr_i = 9'd5; dbg_addr_i = 9'd5; if_addr_i = 9'd5;
        for (int i = 0; i < 100; i++) next_cycle();
        @(negedge clk_i);
        n_checks++;
        if (sram_addr0_o !== 9'd100) $display("FAIL clear_count_100: got %0d want 100", sram_addr0_o);
        else n_pass++;
        // pulse reset for the cycle at clear count 100
        reset_i = 1;
        #1;
        n_checks++;
        if ({sram_csb0_o, ready_o} !== 2'b10)
            $display("FAIL reset_in_clear: got csb0 %b ready %b want 1 0", sram_csb0_o, ready_o);
        else n_pass++;
        next_cycle();
        reset_i = 0;
        run_clear("reclear");
        @(negedge clk_i);
        n_checks++;
        if ({ready_o, d_gnt_o, dbg_gnt_o, if_gnt_o} !== 4'b1101)
            $display("FAIL reclear_ready: got %b want 1101", {ready_o, d_gnt_o, dbg_gnt_o, if_gnt_o});
        else n_pass++;
        next_cycle();
        d_req_i = 0; if_req_i = 0;
        @(negedge clk_i);
        n_checks++;
        if ({d_rvalid_o, d_rdata_o, if_rvalid_o, if_rdata_o} !== {1'b1, 32'h0, 1'b1, 32'h0})
            $display("FAIL reclear_wiped: got d %b/%h if %b/%h want 1/0 1/0", d_rvalid_o, d_rdata_o,
                     if_rvalid_o, if_rdata_o);
        else n_pass++;
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_clear();
        test_round_robin();
        test_byte_mask();
        test_hazard();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, word address width (512 words).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; the byte-mask width is DATA_WIDTH/8 = 4.
REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1; a value of 1 zero-fills the SRAM after reset.
REQ-004 SHALL have one clock (clk_i) and a synchronous, active-high reset (reset_i); all state changes occur on the rising edge of clk_i.
REQ-005 clk_i  in  1  clock; it also clocks both SRAM ports.
REQ-006 reset_i  in  1  synchronous active-high reset.
REQ-007 ready_o  out  1  high once the clear sequence is done; requests are accepted only while it is high.
REQ-008 if_req_i / if_addr_i  in  1 / 9  instruction-fetch read request and word address.
REQ-009 if_gnt_o  out  1  fetch request accepted this cycle.
REQ-010 if_rvalid_o / if_rdata_o  out  1 / 32  fetch read data valid, and the data.
REQ-011 d_req_i / dbg_req_i  in  1  data-master and debug-master requests.
REQ-012 d_we_i / dbg_we_i  in  1  write enable (1 = write, 0 = read).
REQ-013 d_wmask_i / dbg_wmask_i  in  4  byte write mask.
REQ-014 d_addr_i / dbg_addr_i  in  9  word address.
REQ-015 d_wdata_i / dbg_wdata_i  in  32  write data.
REQ-016 d_gnt_o / dbg_gnt_o  out  1  request accepted this cycle.
REQ-017 d_rvalid_o, d_rdata_o / dbg_rvalid_o, dbg_rdata_o  out  1, 32  read data valid, and the data.
REQ-018 sram_csb0_o, sram_web0_o  out  1  port-0 chip select and write enable, both active-low.
REQ-019 sram_wmask0_o / sram_addr0_o / sram_din0_o  out  4 / 9 / 32  port-0 byte mask, address and write data.
REQ-020 sram_dout0_i / sram_dout1_i  in  32  SRAM port-0 / port-1 read data.
REQ-021 sram_csb1_o / sram_addr1_o  out  1 / 9  port-1 chip select and address.
REQ-022 sram_web1_o = 1, sram_wmask1_o = 0, sram_din1_o = 0  out  1 / 4 / 32  constant outputs; port 1 is read-only.

Function
REQ-023 SHALL implement FSM {CLEAR, READY}; state after reset is CLEAR if CLEAR_ON_RESET=1, else READY.
REQ-024 In CLEAR, each cycle SHALL drive port 0 as: csb0=0, web0=0, wmask0=4'hF, din0=0, addr0=clear counter; the counter increments by 1 per cycle.
REQ-025 After the cycle that writes address 511, the FSM SHALL go to READY; ready_o rises the following cycle and stays high until reset.
REQ-026 While ready_o=0, all *_gnt_o SHALL be 0 and sram_csb1_o SHALL be 1.
REQ-027 Port-0 arbitration between d and dbg:
  - round-robin, one priority bit;
  - grant is combinational in the same cycle as the request;
  - after any port-0 grant, priority moves to the other master.
REQ-028 Requesters SHALL hold req and all qualifiers stable until gnt; the arbiter SHALL never grant both d and dbg in one cycle.
REQ-029 On a port-0 grant, the block SHALL drive csb0=0, web0=~we, wmask0 = we ? wmask : 0, addr0 = addr, din0 = wdata; with no grant, csb0=1 and all other port-0 outputs are 0.
REQ-030 Read latency: a read granted in cycle N SHALL give rvalid=1 in cycle N+1 to the granted master only, with rdata = sram_dout of the matching port.
REQ-031 The read owner SHALL be registered in cycle N; writes SHALL produce no rvalid; rdata is don't-care when rvalid=0.
REQ-032 Port 1: if_gnt_o = if_req_i & ready_o & ~hazard; on if_gnt_o the block SHALL drive csb1=0 and addr1=if_addr_i; otherwise csb1=1 and addr1=0.
REQ-033 hazard = a port-0 write granted in the same cycle with addr0 == if_addr_i; the fetch is stalled for that cycle and retried the next cycle.
REQ-034 A write with wmask=0 SHALL still be granted and complete; the SRAM contents are unchanged.
REQ-035 Back-to-back grants every cycle SHALL be supported on both ports, giving full throughput.

Reset
REQ-036 While reset_i is sampled high, the block SHALL hold:
  - all gnt and rvalid = 0, ready_o = 0;
  - csb0 = csb1 = 1;
  - clear counter = 0, priority = d.
REQ-037 Reset asserted during CLEAR SHALL restart the clear from address 0; a read granted in the cycle before reset SHALL produce no rvalid.

Verification
REQ-038 Reset release with CLEAR_ON_RESET=1 -> 512 cycles of port-0 writes to addresses 0..511 with din=0; ready_o=1 in cycle 513; no gnt before that.
REQ-039 d and dbg both request continuously -> grants alternate d, dbg, d, dbg; a read of address 5 after a prior write of 0xDEADBEEF returns rvalid one cycle after gnt with rdata=0xDEADBEEF.
REQ-040 d write to address 0x10 with wmask=4'b0101 and data 0x11223344, over 0 -> a subsequent read of 0x10 returns 0x00220044.
REQ-041 d write to 0x20 and if_req to 0x20 in the same cycle -> if_gnt=0 that cycle, 1 the next cycle; the fetch returns the new data.
REQ-042 reset_i pulsed at clear count 100 -> clear restarts at address 0; ready_o is delayed accordingly.
